awb_pattern_src: RTL

Test-pattern transmitter for the ISP video stream. It generates 4-pixel-per-beat RGB888 frames on the same 96-bit AXI4-Stream video interface that the white-balance and other ISP stages consume: tuser marks the frame start and tlast marks the line end. Downstream tready backpressure is honoured. Its job is to drive the ISP chain with known content, including deliberate colour casts, for bring-up and regression.

---
 rtl/awb_pattern_src.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/awb_pattern_src.sv
// ISP test-pattern transmitter: 4-pixel/beat RGB888 frames on AXI4-Stream video
// (tuser = frame start, tlast = line end), with tready backpressure honoured.

module awb_pix_gen (
  input  logic [1:0]  mode,
  input  logic [23:0] rgb,
  input  logic [2:0]  bar,
  input  logic [7:0]  x,
  input  logic        y3,
  output logic [23:0] pix
);
  always_comb begin
    pix = 24'h0;
    case (mode)
      2'd0: pix = rgb;
      // each bar channel is full-scale or off; one inverted index bit per channel
      2'd1: pix = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
      2'd2: pix = {x, x, x};
      2'd3: pix = (x[3] ^ y3) ? 24'h0 : rgb;
    endcase
  end
endmodule

module awb_pattern_src #(
  parameter int IMG_WIDTH  = 1920,
  parameter int IMG_HEIGHT = 1080,
  parameter int LINE_GAP   = 16,
  parameter int FRAME_GAP  = 64
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_enable,
  input  logic [1:0]  I_mode,
  input  logic [23:0] I_solid_rgb,
  output logic [95:0] O_tdata,
  output logic        O_tuser,
  output logic        O_tlast,
  output logic        O_tvalid,
  input  logic        O_tready,
  output logic        O_frame_done,
  output logic [15:0] O_frame_cnt
);
  localparam int NUM_LANES = 4;
  localparam logic [15:0] BX_LAST  = 16'(IMG_WIDTH / 4 - 1);
  localparam logic [15:0] SUB_LAST = 16'(IMG_WIDTH / 32 - 1);
  localparam logic [15:0] Y_LAST   = 16'(IMG_HEIGHT - 1);
  localparam logic [15:0] LG_LAST  = 16'(LINE_GAP - 1);
  localparam logic [15:0] FG_LAST  = 16'(FRAME_GAP - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, LGAP, FGAP} state_t;

  state_t state, n_state;
  logic [15:0] bx, n_bx, y, n_y, sub, n_sub, gcnt, n_gcnt, fcnt, n_fcnt;
  logic [2:0]  bar, n_bar;
  logic [1:0]  mode, n_mode;
  logic [23:0] rgb, n_rgb;
  logic [NUM_LANES-1:0][23:0] tdata, n_tdata, pix;
  logic tuser, n_tuser, tlast, n_tlast, tvalid, n_tvalid, fdone, n_fdone;
  logic hs, load, line_start;

  assign hs = tvalid & O_tready;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state  <= IDLE;
      bx     <= '0;
      y      <= '0;
      sub    <= '0;
      bar    <= '0;
      gcnt   <= '0;
      fcnt   <= '0;
      mode   <= '0;
      rgb    <= '0;
      tdata  <= '0;
      tuser  <= 1'b0;
      tlast  <= 1'b0;
      tvalid <= 1'b0;
      fdone  <= 1'b0;
    end else begin
      state  <= n_state;
      bx     <= n_bx;
      y      <= n_y;
      sub    <= n_sub;
      bar    <= n_bar;
      gcnt   <= n_gcnt;
      fcnt   <= n_fcnt;
      mode   <= n_mode;
      rgb    <= n_rgb;
      tdata  <= n_tdata;
      tuser  <= n_tuser;
      tlast  <= n_tlast;
      tvalid <= n_tvalid;
      fdone  <= n_fdone;
    end
  end

  // sequencing: counters only move on a handshake or while a gap is running
  always_comb begin
    n_state    = state;
    n_bx       = bx;
    n_y        = y;
    n_sub      = sub;
    n_bar      = bar;
    n_gcnt     = gcnt;
    n_mode     = mode;
    n_rgb      = rgb;
    n_fcnt     = fcnt;
    n_fdone    = 1'b0;
    load       = 1'b0;
    line_start = 1'b0;
    case (state)
      IDLE: if (I_enable) begin
        n_state    = ACTIVE;
        n_mode     = I_mode;
        n_rgb      = I_solid_rgb;
        n_y        = '0;
        line_start = 1'b1;
      end
      ACTIVE: if (hs) begin
        if (bx == BX_LAST) begin
          n_gcnt = '0;
          if (y == Y_LAST) begin
            n_state = FGAP;
            n_fdone = 1'b1;
            n_fcnt  = fcnt + 16'd1;
          end else begin
            n_state = LGAP;
          end
        end else begin
          n_bx = bx + 16'd1;
          load = 1'b1;
          if (sub == SUB_LAST) begin
            n_sub = '0;
            n_bar = bar + 3'd1;
          end else begin
            n_sub = sub + 16'd1;
          end
        end
      end
      LGAP: begin
        if (gcnt == LG_LAST) begin
          n_state    = ACTIVE;
          n_y        = y + 16'd1;
          line_start = 1'b1;
        end else begin
          n_gcnt = gcnt + 16'd1;
        end
      end
      FGAP: begin
        if (gcnt == FG_LAST) begin
          if (I_enable) begin
            n_state    = ACTIVE;
            n_mode     = I_mode;
            n_rgb      = I_solid_rgb;
            n_y        = '0;
            line_start = 1'b1;
          end else begin
            n_state = IDLE;
          end
        end else begin
          n_gcnt = gcnt + 16'd1;
        end
      end
      default: n_state = IDLE;
    endcase
    if (line_start) begin
      n_bx  = '0;
      n_sub = '0;
      n_bar = '0;
      load  = 1'b1;
    end
  end

  // pixels are built from the next-beat counters so the output registers load them directly
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    awb_pix_gen u_pix (
      .mode (n_mode),
      .rgb  (n_rgb),
      .bar  (n_bar),
      .x    ({n_bx[5:0], 2'(k)}),
      .y3   (n_y[3]),
      .pix  (pix[k])
    );
  end

  // output registers hold while a beat is pending and clear when leaving ACTIVE
  always_comb begin
    n_tvalid = (n_state == ACTIVE);
    n_tdata  = tdata;
    n_tuser  = tuser;
    n_tlast  = tlast;
    if (load) begin
      n_tdata = pix;
      n_tuser = (n_bx == 16'd0) && (n_y == 16'd0);
      n_tlast = (n_bx == BX_LAST);
    end else if (n_state != ACTIVE) begin
      n_tdata = '0;
      n_tuser = 1'b0;
      n_tlast = 1'b0;
    end
  end

  assign O_tdata      = tdata;
  assign O_tuser      = tuser;
  assign O_tlast      = tlast;
  assign O_tvalid     = tvalid;
  assign O_frame_done = fdone;
  assign O_frame_cnt  = fcnt;

endmodule
